// File: rtl/analog_bus_arbiter_pkg.sv
// Shared definitions for the analog bus arbiter.
//   arb_state_e : arbiter FSM states
//   CNT_W       : width of the settle/dead counters (holds up to 255)
//   idx_width() : bits needed to index NUM_REQ requesters (never below 1)
package analog_bus_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONNECT = 2'd1,
    ST_OWNED   = 2'd2,
    ST_BREAK   = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/analog_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_owner : index granted most recently; the search starts one above it
//   valid      : at least one request is present
//   index      : first requesting index found after last_owner, wrapping
module rr_priority_pick
  import analog_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [idx_width(NUM_REQ)-1:0] last_owner,
  output logic                          valid,
  output logic [idx_width(NUM_REQ)-1:0] index
);

  localparam int IW = idx_width(NUM_REQ);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_owner is the last (winning) assignment.
  always_comb begin
    valid    = |req;
    index    = last_owner;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand     = (int'(last_owner) + off) % NUM_REQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) index = cand_idx;
    end
  end

endmodule

// File: rtl/analog_bus_arbiter.sv
// Break-before-make arbiter granting one requester at a time onto a shared
// analog bus, with switch-settle delay and optional hold limit.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset (release synchronised internally)
//   req     : level request per requester
//   sw_en   : registered one-hot-or-zero switch enables
//   ready   : registered one-hot-or-zero "connection settled" flags
//   busy    : registered, high whenever the FSM is not IDLE
//   owner   : registered index of the current or last owner
//
// state   | meaning
// IDLE    | all switches open, arbitrate every cycle
// CONNECT | owner's switch closed, waiting SETTLE_CYCLES for settling
// OWNED   | owner's switch closed and ready, hold counter running
// BREAK   | all switches open for DEAD_CYCLES before next arbitration
module analog_bus_arbiter
  import analog_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEAD_CYCLES   = 2,
  parameter int MAX_HOLD      = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            sw_en,
  output logic [NUM_REQ-1:0]            ready,
  output logic                          busy,
  output logic [idx_width(NUM_REQ)-1:0] owner
);

  localparam int IW     = idx_width(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0]     LAST_RST    = IW'(NUM_REQ - 1);

  // Assertion is asynchronous; release reaches the FSM two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_nxt;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]  sw_en_q, sw_en_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  owner_hot, hot_d;
  logic                owner_req, others_pend, hold_hit;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  assign owner_hot   = NUM_REQ'(1) << last_q;
  assign owner_req   = req[last_q];
  assign others_pend = |(req & ~owner_hot);
  assign hold_nxt    = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  // Hold limit trips on the OWNED cycle that brings the count to MAX_HOLD.
  assign hold_hit    = (MAX_HOLD > 0) && (hold_nxt == HOLD_MAX);

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      last_q  <= LAST_RST;
      owner_q <= '0;
      sw_en_q <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      sw_en_q <= sw_en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_CONNECT;
          cnt_d   = SETTLE_LOAD;
          last_d  = pick_idx;
          owner_d = pick_idx;
        end
      end
      ST_CONNECT: begin
        if (!owner_req) begin
          state_d = ST_BREAK;
          cnt_d   = DEAD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_OWNED;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OWNED: begin
        if (!owner_req || (hold_hit && others_pend)) begin
          state_d = ST_BREAK;
          cnt_d   = DEAD_LOAD;
        end else begin
          hold_d = hold_nxt;
        end
      end
      ST_BREAK: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    hot_d   = NUM_REQ'(1) << last_d;
    sw_en_d = '0;
    ready_d = '0;
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_CONNECT || state_d == ST_OWNED) sw_en_d = hot_d;
    if (state_d == ST_OWNED)                          ready_d = hot_d;
  end

  assign sw_en = sw_en_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_analog_bus_arbiter.sv
module tb_analog_bus_arbiter;

  localparam int N  = 4;
  localparam int ST = 4;
  localparam int DC = 2;
  localparam int MH = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] sw_en, ready;
  logic         busy;
  logic [1:0]   owner;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  analog_bus_arbiter #(
    .NUM_REQ(N), .SETTLE_CYCLES(ST), .DEAD_CYCLES(DC), .MAX_HOLD(MH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .sw_en   (sw_en),
    .ready   (ready),
    .busy    (busy),
    .owner   (owner)
  );

  typedef struct {
    string      nm;
    bit         rst;
    int         lo;
    int         hi;
    logic [3:0] r;
    logic [3:0] sw;
    logic [3:0] rd;
    logic       b;
    logic [1:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, bit rst, int lo, int hi, logic [3:0] r,
                              logic [3:0] sw, logic [3:0] rd, logic b, logic [1:0] o);
    vec_t v;
    v.nm = nm; v.rst = rst; v.lo = lo; v.hi = hi; v.r = r;
    v.sw = sw; v.rd = rd; v.b = b; v.o = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_sw_en", 32'(sw_en), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    cyc = 0;
  endtask

  // Reference model: connection age and remaining dead time, in cycles.
  int m_cur, m_age, m_dead, m_last, m_own;

  task automatic model_init();
    m_cur = -1; m_age = 0; m_dead = 0; m_last = N - 1; m_own = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic others;
    bit   force_rel;
    if (m_cur >= 0) begin
      others    = |(r & ~(4'(1 << m_cur)));
      force_rel = (MH > 0) && (m_age >= ST) && ((m_age - ST + 1) >= MH) && others;
      if (!r[m_cur[1:0]] || force_rel) begin
        m_cur  = -1;
        m_dead = DC;
      end else begin
        m_age++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (r != 0) begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_last + off) % N;
        if (m_cur < 0 && r[c[1:0]]) begin
          m_cur = c; m_last = c; m_own = c; m_age = 0;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int          waited;
    int          zrun;
    bit          seen;
    int          bypass[N];
    int          w;
    int          flip_den;
    logic [3:0]  nr, e_sw, e_rd;

    // lone requester, held past the hold limit with nobody else waiting
    tbl.push_back(mk("single",  1,  0,  0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0));
    tbl.push_back(mk("single",  0,  1,  4, 4'h1, 4'h1, 4'h0, 1'b1, 2'd0));
    tbl.push_back(mk("single",  0,  5, 29, 4'h1, 4'h1, 4'h1, 1'b1, 2'd0));
    tbl.push_back(mk("single",  0, 30, 30, 4'h0, 4'h1, 4'h1, 1'b1, 2'd0));
    tbl.push_back(mk("single",  0, 31, 32, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0));
    tbl.push_back(mk("single",  0, 33, 34, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0));
    // contention, owner 0 releases at cycle 10
    tbl.push_back(mk("contend", 1,  0,  0, 4'h5, 4'h0, 4'h0, 1'b0, 2'd0));
    tbl.push_back(mk("contend", 0,  1,  4, 4'h5, 4'h1, 4'h0, 1'b1, 2'd0));
    tbl.push_back(mk("contend", 0,  5,  9, 4'h5, 4'h1, 4'h1, 1'b1, 2'd0));
    tbl.push_back(mk("contend", 0, 10, 10, 4'h4, 4'h1, 4'h1, 1'b1, 2'd0));
    tbl.push_back(mk("contend", 0, 11, 12, 4'h4, 4'h0, 4'h0, 1'b1, 2'd0));
    tbl.push_back(mk("contend", 0, 13, 13, 4'h4, 4'h0, 4'h0, 1'b0, 2'd0));
    tbl.push_back(mk("contend", 0, 14, 17, 4'h4, 4'h4, 4'h0, 1'b1, 2'd2));
    tbl.push_back(mk("contend", 0, 18, 20, 4'h4, 4'h4, 4'h4, 1'b1, 2'd2));
    // abort while settling
    tbl.push_back(mk("abort",   1,  0,  0, 4'h2, 4'h0, 4'h0, 1'b0, 2'd0));
    tbl.push_back(mk("abort",   0,  1,  1, 4'h2, 4'h2, 4'h0, 1'b1, 2'd1));
    tbl.push_back(mk("abort",   0,  2,  2, 4'h0, 4'h2, 4'h0, 1'b1, 2'd1));
    tbl.push_back(mk("abort",   0,  3,  4, 4'h0, 4'h0, 4'h0, 1'b1, 2'd1));
    tbl.push_back(mk("abort",   0,  5,  6, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1));
    // hold limit forces release to requester 1
    tbl.push_back(mk("hold",    1,  0,  0, 4'h3, 4'h0, 4'h0, 1'b0, 2'd0));
    tbl.push_back(mk("hold",    0,  1,  4, 4'h3, 4'h1, 4'h0, 1'b1, 2'd0));
    tbl.push_back(mk("hold",    0,  5, 20, 4'h3, 4'h1, 4'h1, 1'b1, 2'd0));
    tbl.push_back(mk("hold",    0, 21, 22, 4'h3, 4'h0, 4'h0, 1'b1, 2'd0));
    tbl.push_back(mk("hold",    0, 23, 23, 4'h3, 4'h0, 4'h0, 1'b0, 2'd0));
    tbl.push_back(mk("hold",    0, 24, 27, 4'h3, 4'h2, 4'h0, 1'b1, 2'd1));
    tbl.push_back(mk("hold",    0, 28, 30, 4'h3, 4'h2, 4'h2, 1'b1, 2'd1));

    foreach (tbl[t]) begin
      if (tbl[t].rst) do_reset();
      for (int k = tbl[t].lo; k <= tbl[t].hi; k++) begin
        chk({tbl[t].nm, "_sw_en"}, 32'(sw_en), 32'(tbl[t].sw));
        chk({tbl[t].nm, "_ready"}, 32'(ready), 32'(tbl[t].rd));
        chk({tbl[t].nm, "_busy"},  32'(busy),  32'(tbl[t].b));
        chk({tbl[t].nm, "_owner"}, 32'(owner), 32'(tbl[t].o));
        req = tbl[t].r;
        next_cycle();
      end
    end

    // asynchronous reset in the middle of CONNECT
    do_reset();
    req = 4'h1;
    repeat (3) next_cycle();
    chk("arst_pre_sw_en", 32'(sw_en), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sw_en", 32'(sw_en), 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    chk("arst_busy",  32'(busy),  32'h0);
    chk("arst_owner", 32'(owner), 32'h0);
    #2 reset_n = 1'b1;
    req = 4'h8;
    waited = 0;
    while (sw_en == 4'h0 && waited < 12) begin
      @(posedge clock);
      #1;
      waited++;
    end
    chk("arst_latency_ok", 32'(waited >= 2 && waited <= 4), 32'h1);
    chk("arst_grant_sw_en", 32'(sw_en), 32'h8);
    chk("arst_grant_owner", 32'(owner), 32'h3);
    repeat (3) next_cycle();
    chk("arst_settling_ready", 32'(ready), 32'h0);
    next_cycle();
    chk("arst_ready", 32'(ready), 32'h8);

    // random soak against the reference model
    do_reset();
    model_init();
    zrun = 0;
    seen = 1'b0;
    for (int i = 0; i < N; i++) bypass[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      e_sw = (m_cur >= 0) ? 4'(1 << m_cur) : 4'h0;
      e_rd = (m_cur >= 0 && m_age >= ST) ? e_sw : 4'h0;
      chk("soak_sw_en", 32'(sw_en), 32'(e_sw));
      chk("soak_ready", 32'(ready), 32'(e_rd));
      chk("soak_busy",  32'(busy),  32'(m_cur >= 0 || m_dead > 0));
      chk("soak_owner", 32'(owner), 32'(m_own));
      chk("soak_onehot", 32'($onehot0(sw_en)), 32'h1);
      chk("soak_ready_implies_sw", 32'((ready & ~sw_en) == 4'h0), 32'h1);

      if (sw_en != 4'h0 && zrun > 0) begin
        if (seen) chk("soak_dead_gap", 32'(zrun >= DC + 1), 32'h1);
        w = 0;
        for (int i = 0; i < N; i++) if (sw_en[i]) w = i;
        for (int i = 0; i < N; i++) begin
          if (i == w) bypass[i] = 0;
          else if (bypass[i] >= 0 && req[i]) bypass[i]++;
          chk("soak_starvation", 32'(bypass[i] <= N), 32'h1);
        end
      end
      if (sw_en != 4'h0) begin
        seen = 1'b1;
        zrun = 0;
      end else begin
        zrun++;
      end

      flip_den = (((n / 500) % 2) == 1) ? 40 : 6;
      nr = req;
      for (int b = 0; b < N; b++)
        if ($urandom_range(flip_den - 1, 0) == 0) nr[b] = ~nr[b];
      for (int b = 0; b < N; b++) if (!nr[b]) bypass[b] = 0;
      req = nr;
      model_step(nr);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/analog_bus_arbiter.md
ANALOG_BUS_ARBITER -- requirements
Module: analog_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one analog bus (range 2..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: switch-settle cycles before ready is asserted (range 1..255).
REQ-003 SHALL have parameter DEAD_CYCLES, default 2: break-before-make cycles with all switches open (range 1..255).
REQ-004 SHALL have parameter MAX_HOLD, default 0: OWNED cycles before forced release when others are pending; 0 disables the limit.
REQ-005 SHALL have port clock, input, 1: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, NUM_REQ: level request per requester, held high while bus use is wanted.
REQ-008 SHALL have port sw_en, output, NUM_REQ: registered, one-hot-or-zero analog switch enables, one per requester-to-bus connection.
REQ-009 SHALL have port ready, output, NUM_REQ: registered, one-hot-or-zero; high means the owner's connection has settled.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port owner, output, clog2(NUM_REQ): index of the current or last owner.

Function
REQ-012 SHALL implement states IDLE, CONNECT, OWNED and BREAK.
REQ-013 In IDLE with req nonzero, the arbiter SHALL select a winner round-robin, starting at last_owner+1 and wrapping modulo NUM_REQ, then go to CONNECT.
REQ-014 sw_en[winner] SHALL rise on the cycle after the req that won was sampled.
REQ-015 CONNECT SHALL last exactly SETTLE_CYCLES cycles with sw_en high. The transition is then to OWNED, with ready[winner] rising SETTLE_CYCLES cycles after sw_en rose.
REQ-016 If req[owner] is sampled low in CONNECT or OWNED, sw_en and ready SHALL be 0 on the next cycle and the state SHALL go to BREAK. An abort during CONNECT never asserts ready.
REQ-017 BREAK SHALL last exactly DEAD_CYCLES cycles with sw_en equal to 0, then return to IDLE. IDLE arbitrates on its first cycle.
REQ-018 The minimum all-zero gap on sw_en between two owners SHALL be DEAD_CYCLES+1 cycles.
REQ-019 If MAX_HOLD>0 and a hold counter reaches MAX_HOLD in OWNED while any other req bit is high, the block SHALL force BREAK; the pointer then favours the other requesters.
REQ-020 The hold counter SHALL reset on entry to OWNED, count OWNED cycles, and saturate at MAX_HOLD.
REQ-021 If MAX_HOLD is reached with no other requester pending, the owner SHALL keep the bus.
REQ-022 last_owner SHALL update only on entry to CONNECT.
REQ-023 A req bit that rises during CONNECT, OWNED or BREAK SHALL NOT preempt the owner except via REQ-019.
REQ-024 At no time SHALL more than one sw_en bit be high, and ready[i] SHALL imply sw_en[i].
REQ-025 Settle and dead counters SHALL be wide enough for 255 and SHALL NOT wrap.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE and set sw_en=0, ready=0, busy=0 and owner=0.
REQ-027 reset_n low SHALL also set last_owner=NUM_REQ-1, so index 0 wins first, and clear all counters.
REQ-028 Reset deassertion SHALL be synchronised before use. The first arbitration occurs no earlier than the second clock edge after release.
REQ-029 Reset asserted mid-CONNECT or mid-OWNED SHALL open all switches immediately, without waiting for a BREAK.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the counter width constant (8 bits) and the owner-index width function.
REQ-031 Round-robin selection SHALL be a sub-module, rr_priority_pick: combinational, with inputs req and last_owner and outputs valid and index.
REQ-032 All outputs SHALL come directly from flops; no combinational path from req to sw_en.

Verification (NUM_REQ=4, SETTLE_CYCLES=4, DEAD_CYCLES=2)
REQ-033 Single request: req=0001 from cycle 0 -> sw_en=0001 at cycle 1, ready=0001 at cycle 5, busy high from cycle 1.
REQ-034 Contention and release: req=0101 from cycle 0, req[0] drops at cycle 10 -> index 0 wins first, sw_en=0000 for cycles 11-13, sw_en=0100 at cycle 14, ready=0100 at cycle 18.
REQ-035 Abort in settle: req=0010 at cycle 0, dropped at cycle 2 -> sw_en=0010 for cycles 1-2, 0 from cycle 3, ready never high, busy low at cycle 6.
REQ-036 Hold limit (MAX_HOLD=16): req=0011 held -> owner 0 in OWNED from cycle 5, sw_en=0000 at cycle 21, owner=1 with sw_en=0010 at cycle 24.
REQ-037 Async reset: reset_n pulsed low at cycle 3 of CONNECT -> sw_en and ready 0 within the same cycle, no clock edge needed; after release, req=1000 wins index 3 normally.
REQ-038 Random soak: 10k cycles of random req -> one-hot-or-zero sw_en, ready implies sw_en, dead gap of at least 3 cycles, and no requester starved beyond NUM_REQ grants.
